cfg_reg_bank: RTL and testbench
===============================

# cfg_reg_bank

Parametrised configuration register bank with a valid/ready request/response handshake. It replaces the fixed 4-bit-address, always-ready register file in the system control path. It adds:
- Configurable depth and exported-register count.
- Per-register read-only protection.
- Error responses.
- Change-notification strobes for exported registers.

It sits between the system controller FSM and the ALU/UART configuration consumers, in the reference clock domain.

## Interface
- REG_WIDTH, 8, data width of each register.
- ADDR_WIDTH, 4, address width.
- DEPTH, 16, number of implemented registers; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- NUM_EXPORT, 4, registers 0..NUM_EXPORT-1 driven out on Cfg_Regs; must satisfy NUM_EXPORT ≤ DEPTH.
- RESET_VALUES, {8'h00,8'h81,8'h00,8'h00}, NUM_EXPORT*REG_WIDTH reset values; register k occupies bits [k*REG_WIDTH +: REG_WIDTH]. The default 8'h81 gives reg 2: parity enable = 1, parity type = 0, prescale = 32.
- RO_MASK, 0, DEPTH-bit mask; bit i = 1 makes register i read-only.

Ports:
- CLK  in  1  single clock.
- RST  in  1  reset, asynchronous, active-low.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  request accepted when Req_Valid & Req_Ready at the CLK edge.
- Req_Wr  in  1  1 = write, 0 = read.
- Req_Addr  in  ADDR_WIDTH  register address.
- Req_WrData  in  REG_WIDTH  write data.
- Rsp_Valid  out  1  response present.
- Rsp_Ready  in  1  response consumed when Rsp_Valid & Rsp_Ready at the CLK edge.
- Rsp_Data  out  REG_WIDTH  read data; 0 for write responses and error responses.
- Rsp_Err  out  1  error flag for the current response.
- Cfg_Regs  out  NUM_EXPORT*REG_WIDTH  live contents of the exported registers.
- Cfg_Update  out  NUM_EXPORT  one-cycle pulse per exported register written.
- Parity_Err  out  1  sticky parity-fault flag.

## Operation
- Two states:
  - IDLE: no response pending.
  - RESP: Rsp_Valid = 1, response held stable until consumed.
- Req_Ready = (state == IDLE) | Rsp_Ready. This is a combinational path from Rsp_Ready and allows back-to-back requests at one per cycle.
- Transitions:
  - IDLE → RESP on acceptance.
  - In RESP: stay in RESP if a new request is accepted in the same cycle Rsp_Ready is high; go to IDLE if Rsp_Ready is high with no new request.
  - In RESP with Rsp_Ready low: Rsp_Data and Rsp_Err hold.
- Every accepted request produces exactly one response, in order.
- Read, Req_Addr < DEPTH: Rsp_Data = register contents at the acceptance edge, Rsp_Err = 0.
- Write, Req_Addr < DEPTH, RO_MASK bit clear: register updated at the acceptance edge; response Rsp_Data = 0, Rsp_Err = 0.
- Write to a read-only register: no update, Rsp_Err = 1.
- Any access with Req_Addr ≥ DEPTH: no update, Rsp_Data = 0, Rsp_Err = 1.
- Cfg_Update[k] is registered. It is high for exactly the cycle after a successful write to register k < NUM_EXPORT, including when the written data equals the old value. An error write produces no pulse.
- Cfg_Regs reflects register contents combinationally from storage, so a new value is visible the cycle after the write edge.

## Timing
- Reset values:
  - Registers k < NUM_EXPORT take RESET_VALUES; all other registers are 0.
  - state = IDLE; Rsp_Valid = 0, Rsp_Data = 0, Rsp_Err = 0, Cfg_Update = 0, Parity_Err = 0.
  - Req_Ready = 1.
- Latency: request accepted at edge N → Rsp_Valid = 1 after edge N, i.e. first sampled at edge N+1.
- Read-after-write: a read accepted the edge after a write to the same address returns the new data.
- Reset asserted mid-transaction: a pending response is discarded, a partially handshaken request is dropped, and register contents return to their reset values.
- Simultaneous Rsp_Ready and new request in RESP: the old response retires and the new response is loaded on the same edge; Rsp_Valid stays 1.

## Configuration
- REG_FILE_PARITY_EN defined:
  - Each register stores an even-parity bit, computed on write and on reset.
  - A read recomputes parity. On mismatch, the response carries Rsp_Err = 1 with the stored data, and Parity_Err sets and stays 1 until reset.
- REG_FILE_PARITY_EN undefined: no parity storage, and Parity_Err is tied to 0.

## Test plan
- Reset, then read addresses 0..3 with Rsp_Ready = 1 → Rsp_Data = 00, 00, 81, 00, all with Rsp_Err = 0.
- Write 0x5A to addr 1, then read addr 1 back-to-back with Rsp_Ready held 1 → Req_Ready stays 1, and two responses arrive on consecutive cycles: write ack (0/0), then read 0x5A. Cfg_Update = 4'b0010 for one cycle, and Cfg_Regs[15:8] = 0x5A.
- Rsp_Ready = 0 for 5 cycles after a read of addr 2 → Rsp_Valid, Rsp_Data = 0x81 held stable and Req_Ready = 0 throughout; releasing Rsp_Ready retires the response and returns to IDLE.
- With DEPTH = 12 and RO_MASK bit 3 set: a write of 0xFF to addr 3 and a read of addr 13 → each gets Rsp_Err = 1, register 3 is unchanged, and Cfg_Update stays 0.
- Assert RST while in RESP → Rsp_Valid = 0 immediately, and addr 1 reads back 0x00 after release.
- With REG_FILE_PARITY_EN defined: force-invert the stored parity bit of register 5, then read addr 5 → Rsp_Err = 1 and Parity_Err = 1, still 1 after further clean reads.

Source files
------------

// File: rtl/cfg_reg_bank_if.sv
// cfg_reg_bank_if: request/response handshake bundle for cfg_reg_bank.
// The master modport is the controller side, and the slave modport is the register bank side.
interface cfg_reg_bank_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int REG_WIDTH  = 8
);
   logic                  Req_Valid;
   logic                  Req_Ready;
   logic                  Req_Wr;
   logic [ADDR_WIDTH-1:0] Req_Addr;
   logic [REG_WIDTH-1:0]  Req_WrData;
   logic                  Rsp_Valid;
   logic                  Rsp_Ready;
   logic [REG_WIDTH-1:0]  Rsp_Data;
   logic                  Rsp_Err;

   modport master (
      output Req_Valid, Req_Wr, Req_Addr, Req_WrData, Rsp_Ready,
      input  Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Err
   );

   modport slave (
      input  Req_Valid, Req_Wr, Req_Addr, Req_WrData, Rsp_Ready,
      output Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Err
   );
endinterface

// File: rtl/cfg_reg_bank.sv
// cfg_reg_bank: parametrised configuration register bank with a valid/ready
// request/response handshake, read-only protection, error responses and
// change strobes for the exported registers.
// Optional feature: define REG_FILE_PARITY_EN to store a parity bit per
// register. The parity bit is checked on every read, and a failed check drives
// the sticky Parity_Err flag.
module cfg_reg_bank #(
   parameter int                                REG_WIDTH    = 8,
   parameter int                                ADDR_WIDTH   = 4,
   parameter int                                DEPTH        = 16,
   parameter int                                NUM_EXPORT   = 4,
   parameter logic [NUM_EXPORT*REG_WIDTH-1:0]   RESET_VALUES = {8'h00, 8'h81, 8'h00, 8'h00},
   parameter logic [DEPTH-1:0]                  RO_MASK      = '0
) (
   input  logic                             CLK,
   input  logic                             RST,
   cfg_reg_bank_if.slave                    bus,
   output logic [NUM_EXPORT*REG_WIDTH-1:0]  Cfg_Regs,
   output logic [NUM_EXPORT-1:0]            Cfg_Update,
   output logic                             Parity_Err
);

   typedef enum logic {IDLE, RESP} state_t;

   state_t                 state_q, state_d;
   logic                   req_ready;
   logic                   accept;
   logic [REG_WIDTH-1:0]   regs_q [DEPTH];
   logic [DEPTH-1:0]       sel;
   logic                   hit;
   logic                   ro;
   logic [REG_WIDTH-1:0]   rd_data;
   logic                   wr_ok;
   logic [REG_WIDTH-1:0]   rsp_data_d, rsp_data_q;
   logic                   rsp_err_d, rsp_err_q;
   logic [NUM_EXPORT-1:0]  upd_q;
`ifdef REG_FILE_PARITY_EN
   logic [DEPTH-1:0]       par_q;
   logic                   par_bad;
   logic                   perr_q;
`endif

   // Returns the reset value of register k; unexported registers reset to zero.
   function automatic logic [REG_WIDTH-1:0] rst_val(input int unsigned k);
      rst_val = '0;
      for (int unsigned j = 0; j < NUM_EXPORT; j++)
         if (j == k) rst_val = RESET_VALUES[j*REG_WIDTH +: REG_WIDTH];
   endfunction

   assign accept = bus.Req_Valid & req_ready;

   // State register of the handshake FSM.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next state: an accepted request always leaves a response pending.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RESP;
         RESP:    if (accept) state_d = RESP;
                  else if (bus.Rsp_Ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs. Ready passes through from Rsp_Ready so that requests can run back to back.
   always_comb begin
      req_ready     = (state_q == IDLE) | bus.Rsp_Ready;
      bus.Req_Ready = req_ready;
      bus.Rsp_Valid = (state_q == RESP);
      bus.Rsp_Data  = rsp_data_q;
      bus.Rsp_Err   = rsp_err_q;
   end

   // Address decode, read mux and response formation.
   always_comb begin
      sel     = '0;
      hit     = 1'b0;
      ro      = 1'b0;
      rd_data = '0;
`ifdef REG_FILE_PARITY_EN
      par_bad = 1'b0;
`endif
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (bus.Req_Addr == ADDR_WIDTH'(i)) begin
            sel[i]  = 1'b1;
            hit     = 1'b1;
            ro      = RO_MASK[i];
            rd_data = regs_q[i];
`ifdef REG_FILE_PARITY_EN
            par_bad = ((^regs_q[i]) != par_q[i]);
`endif
         end
      end
      wr_ok      = accept & bus.Req_Wr & hit & ~ro;
      rsp_data_d = (hit & ~bus.Req_Wr) ? rd_data : '0;
      rsp_err_d  = ~hit | (bus.Req_Wr & ro);
`ifdef REG_FILE_PARITY_EN
      rsp_err_d  = rsp_err_d | (hit & ~bus.Req_Wr & par_bad);
`endif
   end

   // Response holding registers, which load only on acceptance.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else if (accept) begin
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // Register storage. It also holds the parity bits when the parity option is built in.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= rst_val(i);
`ifdef REG_FILE_PARITY_EN
            par_q[i]  <= ^rst_val(i);
`endif
         end
      end else if (wr_ok) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
               regs_q[i] <= bus.Req_WrData;
`ifdef REG_FILE_PARITY_EN
               par_q[i]  <= ^bus.Req_WrData;
`endif
            end
         end
      end
   end

   // One-cycle change strobe per exported register that was successfully written.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) upd_q <= '0;
      else      upd_q <= wr_ok ? sel[NUM_EXPORT-1:0] : '0;
   end

   assign Cfg_Update = upd_q;

   // Drive the live contents of the exported registers out of the bank.
   always_comb begin
      Cfg_Regs = '0;
      for (int unsigned k = 0; k < NUM_EXPORT; k++)
         Cfg_Regs[k*REG_WIDTH +: REG_WIDTH] = regs_q[k];
   end

`ifdef REG_FILE_PARITY_EN
   // Sticky parity fault. It is set by any accepted read whose parity check fails.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                                  perr_q <= 1'b0;
      else if (accept & ~bus.Req_Wr & hit & par_bad) perr_q <= 1'b1;
   end

   assign Parity_Err = perr_q;
`else
   assign Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_reg_bank.sv
// tb_cfg_reg_bank: scoreboard bench for cfg_reg_bank (DEPTH 12, register 3 read-only).
// Define REG_FILE_PARITY_EN to also exercise the parity-fault path.
module tb_cfg_reg_bank;
   localparam int RW = 8;
   localparam int AW = 4;
   localparam int DEPTH = 12;
   localparam int NE = 4;
   localparam logic [DEPTH-1:0] RO = 12'h008;

   typedef struct {
      logic [RW-1:0] d;
      logic          e;
   } rsp_t;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   logic [NE*RW-1:0] cfg_regs;
   logic [NE-1:0]    cfg_update;
   logic             parity_err;

   int checks = 0;
   int passed = 0;

   logic [RW-1:0] mdl [DEPTH];
   logic          pbad [DEPTH];
   logic          exp_perr;
   logic          busy;
   logic          in_reset;
   logic [NE-1:0] cur_upd;
   rsp_t          q[$];

   always #5 CLK = ~CLK;

   cfg_reg_bank_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) bus ();

   cfg_reg_bank #(
      .REG_WIDTH(RW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_EXPORT(NE),
      .RESET_VALUES({8'h00, 8'h81, 8'h00, 8'h00}), .RO_MASK(RO)
   ) dut (
      .CLK(CLK), .RST(RST), .bus(bus.slave),
      .Cfg_Regs(cfg_regs), .Cfg_Update(cfg_update), .Parity_Err(parity_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         mdl[i]  = '0;
         pbad[i] = 1'b0;
      end
      mdl[2]   = 8'h81;
      exp_perr = 1'b0;
      busy     = 1'b0;
      cur_upd  = '0;
   endfunction

   // One bus cycle: drive the inputs at the falling edge, predict the result, then move to the rising edge.
   task automatic step(input logic v, input logic wr, input logic [AW-1:0] a,
                       input logic [RW-1:0] d, input logic rr, output logic acc);
      rsp_t r;
      logic [NE-1:0] nu;
      logic pe_next;
      @(negedge CLK);
      bus.Req_Valid = v; bus.Req_Wr = wr; bus.Req_Addr = a;
      bus.Req_WrData = d; bus.Rsp_Ready = rr;
      #1;
      chk("req_ready", bus.Req_Ready, !busy || rr);
      chk("rsp_valid", bus.Rsp_Valid, busy);
      acc = v && bus.Req_Ready;
      nu = '0;
      pe_next = exp_perr;
      if (acc) begin
         if (int'(a) >= DEPTH) begin
            r.d = '0; r.e = 1'b1;
         end else if (wr) begin
            r.d = '0; r.e = RO[a];
            if (!RO[a] && int'(a) < NE) nu[a] = 1'b1;
         end else begin
            r.d = mdl[a]; r.e = pbad[a];
            if (pbad[a]) pe_next = 1'b1;
         end
         q.push_back(r);
      end
      @(posedge CLK);
      if (acc && wr && int'(a) < DEPTH && !RO[a]) begin
         mdl[a]  = d;
         pbad[a] = 1'b0;
      end
      cur_upd  = nu;
      exp_perr = pe_next;
      busy     = acc ? 1'b1 : (rr ? 1'b0 : busy);
   endtask

   // Response monitor: retire one expected response on each consumed response, and check the side outputs.
   always @(negedge CLK) begin
      rsp_t e;
      #2;
      if (!in_reset) begin
         if (bus.Rsp_Valid && bus.Rsp_Ready) begin
            if (q.size() == 0) begin
               chk("rsp_unexpected", 1, 0);
            end else begin
               e = q.pop_front();
               chk("rsp_data", bus.Rsp_Data, e.d);
               chk("rsp_err", bus.Rsp_Err, e.e);
            end
         end
         chk("cfg_update", cfg_update, cur_upd);
         chk("cfg_regs", cfg_regs, {mdl[3], mdl[2], mdl[1], mdl[0]});
         chk("parity_err", parity_err, exp_perr);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic acc;
      logic v, wr, rr;
      logic [AW-1:0] a;
      logic [RW-1:0] d;
`ifdef REG_FILE_PARITY_EN
      logic [DEPTH-1:0] ptmp;
`endif
      in_reset = 1'b1;
      bus.Req_Valid = 0; bus.Req_Wr = 0; bus.Req_Addr = '0;
      bus.Req_WrData = '0; bus.Rsp_Ready = 0;
      model_reset();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_req_ready", bus.Req_Ready, 1);
      chk("rst_rsp_valid", bus.Rsp_Valid, 0);
      chk("rst_rsp_data", bus.Rsp_Data, 0);
      chk("rst_rsp_err", bus.Rsp_Err, 0);
      chk("rst_cfg_update", cfg_update, 0);
      chk("rst_parity_err", parity_err, 0);
      chk("rst_cfg_regs", cfg_regs, 32'h0081_0000);
      RST = 1'b1;
      in_reset = 1'b0;

      // Reset values of the exported registers.
      for (int i = 0; i < 4; i++) step(1, 0, AW'(i), 0, 1, acc);
      // Write followed by a back-to-back read of the same address.
      step(1, 1, 1, 8'h5A, 1, acc);
      step(1, 0, 1, 0, 1, acc);
      step(0, 0, 0, 0, 1, acc);
      // Response stalled for 5 cycles.
      step(1, 0, 2, 0, 1, acc);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 0, acc);
         #1 chk("stall_data", bus.Rsp_Data, 8'h81);
      end
      step(0, 0, 0, 0, 1, acc);
      step(0, 0, 0, 0, 1, acc);
      // Read-only register, out-of-range accesses and the DEPTH boundary.
      step(1, 1, 3, 8'hFF, 1, acc);
      step(1, 0, 13, 0, 1, acc);
      step(1, 0, 3, 0, 1, acc);
      step(1, 1, 12, 8'h33, 1, acc);
      step(1, 1, 11, 8'hC4, 1, acc);
      step(1, 0, 11, 0, 1, acc);
      step(1, 0, 12, 0, 1, acc);
      // Reset while a response is pending (register 1 still holds 5A here).
      step(1, 0, 1, 0, 0, acc);
      step(0, 0, 0, 0, 0, acc);
      @(negedge CLK);
      in_reset = 1'b1;
      RST = 1'b0;
      #1;
      chk("midrst_rsp_valid", bus.Rsp_Valid, 0);
      chk("midrst_req_ready", bus.Req_Ready, 1);
      q.delete();
      model_reset();
      @(negedge CLK);
      RST = 1'b1;
      in_reset = 1'b0;
      step(1, 0, 1, 0, 1, acc);
      step(0, 0, 0, 0, 1, acc);
      // Randomized traffic with random backpressure.
      repeat (400) begin
         v  = ($urandom_range(0, 3) != 0);
         wr = ($urandom_range(0, 1) != 0);
         a  = AW'($urandom_range(0, 15));
         d  = RW'($urandom);
         rr = ($urandom_range(0, 3) != 0);
         step(v, wr, a, d, rr, acc);
      end
      step(0, 0, 0, 0, 1, acc);
      step(0, 0, 0, 0, 1, acc);
`ifdef REG_FILE_PARITY_EN
      ptmp = dut.par_q;
      ptmp[5] = ~ptmp[5];
      force dut.par_q = ptmp;
      pbad[5] = 1'b1;
      step(1, 0, 5, 0, 1, acc);
      step(1, 0, 0, 0, 1, acc);
      step(1, 0, 2, 0, 1, acc);
      step(0, 0, 0, 0, 1, acc);
      step(0, 0, 0, 0, 1, acc);
      release dut.par_q;
`endif
      for (int i = 0; i < 50 && (q.size() != 0 || busy); i++)
         step(0, 0, 0, 0, 1, acc);
      chk("drain_queue", q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
